mem_req_initiator: RTL and testbench

- Core-side initiator for the data-memory valid/yumi handshake.
- Accepts one load or store per transaction from the pipeline and registers it.
- Drives the request onto the memory's mem_in_s port, then waits for the memory's response and acknowledges it with yumi.
- Returns load data (optionally sign-extended), a stall signal, and error flags for misalignment and timeout. Sits between the core's memory stage and data_mem.

---
 rtl/mem_req_initiator.sv | 194 +++++++++++++++++++
 tb/tb_mem_req_initiator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_initiator.sv
// rtl/mem_req_initiator.sv - core-side valid/yumi initiator for the data memory
//
// Registers one load or store from the memory stage, issues it to data_mem,
// waits for the response, acknowledges it with yumi and returns load data.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   req_valid_i         access request, sampled only in IDLE
//   req_wen_i           1 = store, 0 = load
//   req_byte_i          1 = byte access, 0 = 32-bit word
//   req_sext_i          byte loads: 1 = sign-extend bit 7
//   req_addr_i          byte address
//   req_wdata_i         store data ([7:0] used by byte stores)
//   stall_o             hold the pipeline while an access is accepted/outstanding
//   resp_valid_o        one-cycle completion pulse
//   resp_rdata_o        load data, held until the next load completes
//   err_unaligned_o     pulse: misaligned word request was dropped
//   err_timeout_o       pulse: transaction aborted by timeout
//   out_of_range_o      address above addr_width_p for the in-flight access
//   port_flat_o         to memory: {valid, wen, byte_not_word, write_data[31:0], yumi}
//   addr_o              to memory address input
//   port_flat_i         from memory: {valid, yumi, read_data[31:0]}
module mem_req_initiator #(
  parameter int addr_width_p = 12,
  parameter int timeout_p    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic        req_byte_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        err_unaligned_o,
  output logic        err_timeout_o,
  output logic        out_of_range_o,
  output logic [35:0] port_flat_o,
  output logic [31:0] addr_o,
  input  logic [33:0] port_flat_i
);

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic        valid;
    logic        yumi;
    logic [31:0] read_data;
  } mem_out_s;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state;
  state_e      state_n;
  logic [7:0]  cnt;
  logic        wen_r;
  logic        byte_r;
  logic        sext_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  mem_in_s     port_o;
  mem_out_s    port_i;

  logic        misaligned;
  logic        timeout_hit;
  logic        accept;
  logic        drop;
  logic        complete;
  logic        abort;
  logic [31:0] load_data;

  assign port_i      = port_flat_i;
  assign port_flat_o = port_o;
  assign addr_o      = addr_r;

  // Byte accesses can never be misaligned.
  assign misaligned  = !req_byte_i && (req_addr_i[1:0] != 2'b00);

  // >= rather than == so a late memory yumi taken on the last REQ cycle
  // still times out on the following WAIT cycle if no data arrives.
  assign timeout_hit = (cnt >= 8'(timeout_p - 1));

  assign load_data = byte_r ? {{24{sext_r & port_i.read_data[7]}}, port_i.read_data[7:0]}
                            : port_i.read_data;

  // Combinational in IDLE so the pipeline freezes in the same cycle it asks.
  assign stall_o = (state != S_IDLE) || (req_valid_i && !misaligned);

  always_comb begin
    state_n              = state;
    accept               = 1'b0;
    drop                 = 1'b0;
    complete             = 1'b0;
    abort                = 1'b0;
    port_o               = '0;
    port_o.wen           = wen_r;
    port_o.byte_not_word = byte_r;
    port_o.write_data    = wdata_r;

    case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (misaligned) begin
            drop = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        port_o.valid = 1'b1;
        // A response valid seen here is a protocol violation and is ignored.
        if (port_i.yumi) begin
          state_n = S_WAIT;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        // A response in the timeout cycle still completes normally.
        if (port_i.valid) begin
          port_o.yumi = 1'b1;
          complete    = 1'b1;
          state_n     = S_IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      wen_r           <= 1'b0;
      byte_r          <= 1'b0;
      sext_r          <= 1'b0;
      addr_r          <= 32'd0;
      wdata_r         <= 32'd0;
      resp_valid_o    <= 1'b0;
      resp_rdata_o    <= 32'd0;
      err_unaligned_o <= 1'b0;
      err_timeout_o   <= 1'b0;
      out_of_range_o  <= 1'b0;
    end else begin
      state           <= state_n;
      resp_valid_o    <= complete;
      err_unaligned_o <= drop;
      err_timeout_o   <= abort;

      if (accept) begin
        wen_r          <= req_wen_i;
        byte_r         <= req_byte_i;
        sext_r         <= req_sext_i;
        addr_r         <= req_addr_i;
        wdata_r        <= req_wdata_i;
        cnt            <= 8'd0;
        out_of_range_o <= ((req_addr_i >> addr_width_p) != 32'd0);
      end else if (state != S_IDLE) begin
        cnt <= cnt + 8'd1;
      end

      if (complete || abort) begin
        out_of_range_o <= 1'b0;
      end

      if (complete && !wen_r) begin
        resp_rdata_o <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb/tb_mem_req_initiator.sv - self-checking bench for mem_req_initiator
module tb_mem_req_initiator;

  localparam int TO = 8;
  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_wen_i = 1'b0;
  logic        req_byte_i = 1'b0;
  logic        req_sext_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        err_unaligned_o;
  logic        err_timeout_o;
  logic        out_of_range_o;
  logic [35:0] port_flat_o;
  logic [31:0] addr_o;
  logic [33:0] port_flat_i;

  mem_req_initiator #(.addr_width_p(12), .timeout_p(TO)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid_i(req_valid_i),
    .req_wen_i(req_wen_i),
    .req_byte_i(req_byte_i),
    .req_sext_i(req_sext_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .stall_o(stall_o),
    .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o),
    .err_unaligned_o(err_unaligned_o),
    .err_timeout_o(err_timeout_o),
    .out_of_range_o(out_of_range_o),
    .port_flat_o(port_flat_o),
    .addr_o(addr_o),
    .port_flat_i(port_flat_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory environment: accepts whenever no response is pending, answers
  // one cycle later; byte reads carry junk in the upper 24 bits.
  logic [7:0]  mem [0:8191];
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        withhold = 1'b0;
  wire         d_valid = port_flat_o[35];
  wire         d_wen   = port_flat_o[34];
  wire         d_byte  = port_flat_o[33];
  wire [31:0]  d_wdata = port_flat_o[32:1];
  wire         d_yumi  = port_flat_o[0];
  wire         mem_yumi = !mem_valid;
  wire [12:0]  ma = addr_o[12:0];
  assign port_flat_i = {mem_valid, mem_yumi, mem_rdata};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_valid && d_yumi) mem_valid <= 1'b0;
      if (d_valid && mem_yumi) begin
        if (d_wen) begin
          if (d_byte) begin
            mem[ma] <= d_wdata[7:0];
          end else begin
            mem[ma]         <= d_wdata[7:0];
            mem[ma + 13'd1] <= d_wdata[15:8];
            mem[ma + 13'd2] <= d_wdata[23:16];
            mem[ma + 13'd3] <= d_wdata[31:24];
          end
        end else begin
          mem_rdata <= d_byte ? {24'h5A5A5A, mem[ma]}
                              : {mem[ma + 13'd3], mem[ma + 13'd2], mem[ma + 13'd1], mem[ma]};
        end
        mem_valid <= !withhold;
      end
    end
  end

  // Reference model: per-cycle expectations derived from transaction timing.
  logic [7:0]  ref_mem [0:8191];
  bit          e_stall [NC];
  bit          e_resp  [NC];
  bit          e_eun   [NC];
  bit          e_eto   [NC];
  bit          e_pv    [NC];
  bit          e_py    [NC];
  bit          f_chk   [NC];
  bit          e_oor   [NC];
  bit          e_wen   [NC];
  bit          e_byte  [NC];
  bit          rd_upd  [NC];
  logic [31:0] e_addr  [NC];
  logic [31:0] e_wdata [NC];
  logic [31:0] rd_val  [NC];

  int n_chk = 0;
  int n_err = 0;
  bit checking = 1'b0;
  logic [31:0] cur_rdata = 32'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] a, input bit bw, input bit sx);
    logic [7:0] b;
    if (bw) begin
      b = ref_mem[a[12:0]];
      if (sx && b >= 8'h80) return 32'hFFFFFF00 | {24'h0, b};
      return {24'h0, b};
    end
    return {ref_mem[a[12:0] + 13'd3], ref_mem[a[12:0] + 13'd2],
            ref_mem[a[12:0] + 13'd1], ref_mem[a[12:0]]};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      cur_rdata = 32'd0;
    end else if (cyc < NC) begin
      if (rd_upd[cyc]) cur_rdata = rd_val[cyc];
      if (checking) begin
        chk("stall", stall_o, e_stall[cyc]);
        chk("resp_valid", resp_valid_o, e_resp[cyc]);
        chk("err_unaligned", err_unaligned_o, e_eun[cyc]);
        chk("err_timeout", err_timeout_o, e_eto[cyc]);
        chk("port_valid", d_valid, e_pv[cyc]);
        chk("port_yumi", d_yumi, e_py[cyc]);
        chk("resp_rdata", resp_rdata_o, cur_rdata);
        if (f_chk[cyc]) begin
          chk("addr", addr_o, e_addr[cyc]);
          chk("wen", d_wen, e_wen[cyc]);
          chk("byte_not_word", d_byte, e_byte[cyc]);
          chk("write_data", d_wdata, e_wdata[cyc]);
          chk("out_of_range", out_of_range_o, e_oor[cyc]);
        end
      end
    end
  end

  // Drive one request in the current cycle and return in the cycle the next
  // request may be issued (the resp_valid cycle for completed accesses).
  task automatic issue(input bit wen, input bit bw, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input bit to);
    int c;
    int dur;
    int last;
    c = cyc;
    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_byte_i  = bw;
    req_sext_i  = sx;
    req_addr_i  = a;
    req_wdata_i = wd;
    if (!bw && a[1:0] != 2'b00) begin
      e_eun[c + 1] = 1'b1;
      dur = 1;
    end else begin
      last = to ? c + TO : c + 2;
      for (int i = c; i <= last; i++) e_stall[i] = 1'b1;
      e_pv[c + 1] = 1'b1;
      for (int i = c + 1; i <= last; i++) begin
        f_chk[i]   = 1'b1;
        e_addr[i]  = a;
        e_wen[i]   = wen;
        e_byte[i]  = bw;
        e_wdata[i] = wd;
        e_oor[i]   = (a >= 32'd4096);
      end
      if (to) begin
        e_eto[c + TO + 1] = 1'b1;
        dur = TO + 1;
      end else begin
        e_py[c + 2]   = 1'b1;
        e_resp[c + 3] = 1'b1;
        dur = 3;
        if (wen) begin
          ref_mem[a[12:0]] = wd[7:0];
          if (!bw) begin
            ref_mem[a[12:0] + 13'd1] = wd[15:8];
            ref_mem[a[12:0] + 13'd2] = wd[23:16];
            ref_mem[a[12:0] + 13'd3] = wd[31:24];
          end
        end else begin
          rd_upd[c + 3] = 1'b1;
          rd_val[c + 3] = load_val(a, bw, sx);
        end
      end
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    while (cyc < c + dur) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_err_unaligned", err_unaligned_o, 0);
    chk("rst_err_timeout", err_timeout_o, 0);
    chk("rst_oor", out_of_range_o, 0);
    chk("rst_port", port_flat_o, 0);
    chk("rst_addr", addr_o, 0);
    reset = 1'b1;
    checking = 1'b1;
    @(posedge clk); #1;

    issue(1, 0, 0, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 0, 0, 32'h10, 32'h0, 0);
    chk("lit_word_load_valid", resp_valid_o, 1);
    chk("lit_word_load", resp_rdata_o, 32'hDEADBEEF);
    issue(1, 0, 0, 32'h0, 32'h11223344, 0);
    issue(1, 1, 0, 32'h21, 32'h12345680, 0);
    issue(0, 1, 1, 32'h21, 32'h0, 0);
    chk("lit_byte_sext", resp_rdata_o, 32'hFFFFFF80);
    issue(0, 1, 0, 32'h21, 32'h0, 0);
    chk("lit_byte_zext", resp_rdata_o, 32'h00000080);
    issue(0, 0, 0, 32'h13, 32'h0, 0);
    chk("lit_unaligned", err_unaligned_o, 1);
    issue(0, 1, 0, 32'h13, 32'h0, 0);
    chk("lit_byte_0x13", resp_rdata_o, 32'h000000DE);

    withhold = 1'b1;
    issue(0, 0, 0, 32'h40, 32'h0, 1);
    chk("lit_timeout", err_timeout_o, 1);
    chk("lit_timeout_no_resp", resp_valid_o, 0);
    withhold = 1'b0;
    issue(0, 0, 0, 32'h10, 32'h0, 0);
    chk("lit_after_timeout", resp_rdata_o, 32'hDEADBEEF);

    issue(1, 0, 0, 32'h1000, 32'hCAFEF00D, 0);
    chk("lit_oor_resp", resp_valid_o, 1);
    issue(0, 0, 0, 32'h0, 32'h0, 0);
    chk("lit_load_0", resp_rdata_o, 32'h11223344);

    // Reset asserted while the load is in WAIT.
    checking = 1'b0;
    req_valid_i = 1'b1;
    req_wen_i   = 1'b0;
    req_byte_i  = 1'b0;
    req_addr_i  = 32'h10;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_stall", stall_o, 1);
    chk("pre_rst_yumi", d_yumi, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_stall", stall_o, 0);
    chk("arst_resp_valid", resp_valid_o, 0);
    chk("arst_rdata", resp_rdata_o, 0);
    chk("arst_err_unaligned", err_unaligned_o, 0);
    chk("arst_err_timeout", err_timeout_o, 0);
    chk("arst_oor", out_of_range_o, 0);
    chk("arst_port", port_flat_o, 0);
    chk("arst_addr", addr_o, 0);
    for (int i = cyc; i < NC; i++) begin
      e_stall[i] = 1'b0; e_resp[i] = 1'b0; e_eun[i] = 1'b0; e_eto[i] = 1'b0;
      e_pv[i] = 1'b0; e_py[i] = 1'b0; f_chk[i] = 1'b0; rd_upd[i] = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    checking = 1'b1;
    issue(0, 0, 0, 32'h10, 32'h0, 0);
    chk("lit_after_reset", resp_rdata_o, 32'hDEADBEEF);
    chk("lit_after_reset_valid", resp_valid_o, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
